// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
package mdu_pkg;

    // Number of datapath iterations per operation (one result bit per cycle).
    localparam int MDU_ITERS = 32;

    // Operation encodings as presented on the op input.
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit. Operands are latched as
// magnitudes at start, a shared 64-bit working register runs 32 shift-add
// or restoring-divide steps, and sign correction is applied once at the end.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] CNT_LAST = 5'(MDU_ITERS - 1);

    mdu_state_e         state_r;
    logic [4:0]         cnt_r;
    logic [1:0]         op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic               div0_r;
    logic [WIDTH-1:0]   a_orig_r;
    logic [WIDTH-1:0]   opb_r;
    logic [2*WIDTH-1:0] work_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               start_signed_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               is_div_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] work_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic [WIDTH-1:0]   fin_lo_s;

    // Magnitude of an operand: two's-complement absolute value for signed
    // ops (the most negative value maps to itself, read as unsigned).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Operand conditioning for the start request.
    always_comb begin
        start_signed_s = (op == MDU_MULT) || (op == MDU_DIV);
        mag_a_s        = magnitude(operand_a, start_signed_s);
        mag_b_s        = magnitude(operand_b, start_signed_s);
    end

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        is_div_s   = (op_r == MDU_DIV) || (op_r == MDU_DIVU);
        mul_sum_s  = {1'b0, work_r[2*WIDTH-1:WIDTH]} +
                     (work_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        // Partial remainder shifted left with the next dividend bit, minus divisor.
        div_diff_s = {1'b0, work_r[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_r};
        if (is_div_s) begin
            if (!div_diff_s[WIDTH+1]) begin
                work_next_s = {div_diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
            end else begin
                work_next_s = {work_r[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            work_next_s = {mul_sum_s, work_r[WIDTH-1:1]};
        end
    end

    // Final sign correction and divide-by-zero result selection.
    always_comb begin
        prod_s = work_r;
        quot_s = work_r[WIDTH-1:0];
        rem_s  = work_r[2*WIDTH-1:WIDTH];
        if (is_div_s) begin
            if (div0_r) begin
                fin_lo_s = {WIDTH{1'b1}};
                fin_hi_s = a_orig_r;
            end else begin
                fin_lo_s = ((op_r == MDU_DIV) && (sign_a_r ^ sign_b_r)) ? (~quot_s) + {{(WIDTH-1){1'b0}}, 1'b1} : quot_s;
                fin_hi_s = ((op_r == MDU_DIV) && sign_a_r) ? (~rem_s) + {{(WIDTH-1){1'b0}}, 1'b1} : rem_s;
            end
        end else begin
            if ((op_r == MDU_MULT) && (sign_a_r ^ sign_b_r)) begin
                prod_s = (~work_r) + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end else begin
                prod_s = work_r;
            end
            fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fin_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer, operand latches and working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            op_r     <= 2'b00;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            div0_r   <= 1'b0;
            a_orig_r <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            work_r   <= {(2*WIDTH){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        sign_a_r <= start_signed_s & operand_a[WIDTH-1];
                        sign_b_r <= start_signed_s & operand_b[WIDTH-1];
                        div0_r   <= (operand_b == {WIDTH{1'b0}});
                        a_orig_r <= operand_a;
                        opb_r    <= mag_b_s;
                        work_r   <= {{WIDTH{1'b0}}, mag_a_s};
                        cnt_r    <= 5'd0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    done_r <= 1'b0;
                    work_r <= work_next_s;
                    cnt_r  <= cnt_r + 5'd1;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // HI/LO registers: result write at FINISH, MTHI/MTLO only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_FINISH) begin
            hi_r <= fin_hi_s;
            lo_r <= fin_lo_s;
        end else if (!busy_r) begin
            if (hi_we) begin
                hi_r <= wdata;
            end
            if (lo_we) begin
                lo_r <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, handshake,
// MTHI/MTLO behaviour and asynchronous reset.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vec_cnt;
    int err_cnt;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start request; it is sampled at the next edge E.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        tick();
        start     = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0BAD_F00D;
    endtask

    // Wait for done after a start edge, checking busy, latency and results.
    // With disturb set, a start plus MTHI is pulsed at RUN cycle 10.
    task automatic wait_result(input string tag, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input bit disturb);
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (disturb && n == 10) begin
                start     = 1'b1;
                op        = 2'b01;
                operand_a = 32'd3;
                operand_b = 32'd3;
                hi_we     = 1'b1;
                wdata     = 32'h5555_5555;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        check_val({tag, "_latency"}, 32'(n), 32'd33);
        check_val({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        check_val({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = 32'd0;
        operand_b = 32'd0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = 32'd0;

        // Reset state.
        tick();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        tick();

        // MTLO / MTHI in idle.
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        lo_we = 1'b0;
        check_val("mtlo", lo, 32'h0000_1234);
        hi_we = 1'b1;
        wdata = 32'h0000_ABCD;
        tick();
        hi_we = 1'b0;
        check_val("mthi", hi, 32'h0000_ABCD);
        check_val("mthi_lo_kept", lo, 32'h0000_1234);

        // Arithmetic vectors, issued back-to-back while done is high.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check_val("done_pulse", {31'd0, done}, 32'd1);
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        check_val("done_one_cycle", {31'd0, done}, 32'd0);
        wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_result("mult_minmin", 32'h4000_0000, 32'h0000_0000, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(2'b11, 32'd100, 32'd7);
        wait_result("divu", 32'd2, 32'd14, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);
        issue(2'b11, 32'd5, 32'd0);
        wait_result("divu_zero", 32'd5, 32'hFFFF_FFFF, 1'b0);
        issue(2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_result("div_zero", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

        // Start and MTHI while busy are both ignored.
        issue(2'b11, 32'd100, 32'd7);
        wait_result("busy_ign", 32'd2, 32'd14, 1'b1);
        tick();
        tick();
        check_val("no_queued_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of RUN.
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 12; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_done", {31'd0, done}, 32'd0);
        check_val("arst_hi", hi, 32'd0);
        check_val("arst_lo", lo, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(2'b11, 32'd9, 32'd3);
        wait_result("post_rst", 32'd0, 32'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
